upcounter_lim: RTL and testbench
================================

// Module: upcounter_lim
// PURPOSE
//  Loadable synchronous up-counter with a programmable terminal value (limit).
//  It is the counting-up counterpart of the down-counter: it counts toward the limit and flags terminal count.
//  Used by controllers that iterate an index from a start value up to a bound
//  (loop indices, address sequencing).
//  Built from the team's bit-slice cells: register slice, HA/FA ripple chain, c1 compare logic.
// PARAMETERS
//  N    5   counter, load and limit width in bits
// PORTS
//  clk     in   1  clock; all state changes on its rising edge
//  clr     in   1  reset; synchronous, active-high
//  ld      in   1  load start value: out <= in
//  in      in   N  start value for ld
//  ld_lim  in   1  load limit register: lim_q <= lim
//  lim     in   N  terminal value for ld_lim
//  cnten   in   1  count enable; increment by one when set
//  wrap    in   1  1 = wrap to 0 after the limit; 0 = saturate (hold) at the limit
//  out     out  N  current count, registered
//  tc      out  1  combinational; asserted when out == lim_q
//  ov      out  1  registered; one-cycle pulse on each terminal-count event
// BEHAVIOUR
//  - Reset (clr=1 at the edge): out=0, lim_q={N{1'b1}}, ov=0; tc=0 after reset (N>=1).
//  - Priority at each edge: clr > ld > cnten. ld_lim is independent of that chain and is ignored only by clr.
//  - ld=1: out<=in, ov<=0, cnten is ignored that cycle.
//  - cnten=1 and out!=lim_q: out<=(out+1) mod 2^N, ov<=0.
//     * Passing 2^N-1 to 0 below the limit (e.g. in>lim_q) is a silent wrap; ov is not set.
//  - cnten=1 and out==lim_q (terminal event): ov<=1 for exactly one cycle.
//     * If wrap=1: out<=0.
//     * If wrap=0: out holds lim_q. Each further cnten cycle at the limit is another
//       terminal event, so ov pulses again on each one.
//  - cnten=0 with no ld: out holds, ov<=0.
//  - ld_lim in the same cycle as a count: the compare uses the old lim_q; the new lim_q is visible next cycle.
//  - lim_q=0 with wrap=1 and counting: out stays at 0 and ov stays high every cycle.
//  - Latency: out, ov and lim_q update one edge after their inputs are sampled; tc follows out combinationally.
//  - clr asserted mid-count overrides ld, cnten and ld_lim that cycle; counting resumes the cycle after clr drops.
//  - Arithmetic: unsigned, N-bit. Carry-out of the increment chain is discarded; it is not ov.
//  - Next-state mux for out:
//     * ld        -> in
//     * inc       -> out+1
//     * term&wrap -> 0
//     * else      -> out
// STRUCTURE
//  - Shared include (cad_defs.vh) holds:
//     * default width CNT_W=5
//     * reset value of the limit, LIM_RST={CNT_W{1'b1}}
//     * mode encodings WRAP=1'b1 and SAT=1'b0
//  - One natural sub-module, upcnt_slice (one per bit, via generate). It contains:
//     * the s2 register cell with ld/clr muxing
//     * the HA (bit 0) or FA (bit>0) of the +1 chain
//     * an XNOR against lim_q[i] that feeds a c1-based AND tree for tc
//  - lim_q is an N-bit bank of s2 cells.
//  - ov is a single s2 flop driven by cnten & tc & ~ld & ~clr.
// TESTING (N=5)
//  1. Reset then idle: clr=1 for 1 cycle -> out=0, lim_q=31, ov=0, tc=0, and the values hold with cnten=0.
//  2. ld_lim with lim=5, wrap=1, cnten=1 from out=0 -> out steps 1,2,3,4,5, then 0.
//     ov is high for exactly the one cycle out=0 follows out=5.
//  3. Saturate: lim=3, wrap=0, cnten held from 0 -> out=3 and stays 3; ov pulses every cycle while at 3.
//  4. ld of in=29, lim=2, wrap=1 -> out steps 30,31,0,1,2, with no ov at the 31->0 step.
//     Then out=0 with ov=1.
//  5. Simultaneous events at out=4, lim_q=4:
//     * ld=1 with in=10 and cnten=1 -> out=10, ov=0.
//     * Separately, ld_lim=1 with lim=9 and cnten=1 -> terminal event against the old limit (out=0, ov=1), new lim_q=9.
//  6. clr asserted at out=17 with cnten=1 and ld=1 -> next cycle out=0, ov=0, lim_q=31.
//     Counting resumes 1,2,... after clr drops.

Source files
------------

// File: rtl/upcounter_lim_pkg.sv
// Shared constants for the limit up-counter: default width, limit reset value, mode encodings.
// No logic, no latency; no flow control.
// Imported by the interface, the bit slice and the top.
package upcounter_lim_pkg;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LIM_RST = {CNT_W{1'b1}};

    // Value of the wrap input that selects each terminal-count behaviour
    localparam logic WRAP = 1'b1;
    localparam logic SAT  = 1'b0;

endpackage

// File: rtl/upcounter_lim_if.sv
// Control/status bundle of the limit up-counter.
// Master drives load/limit/count controls; slave returns count, tc and ov.
// No flow control: every control is sampled on each rising clock edge.
interface upcounter_lim_if #(
    parameter int N = 5
);
    logic         ld;
    logic [N-1:0] in;
    logic         ld_lim;
    logic [N-1:0] lim;
    logic         cnten;
    logic         wrap;
    logic [N-1:0] out;
    logic         tc;
    logic         ov;

    modport master (
        output ld, in, ld_lim, lim, cnten, wrap,
        input  out, tc, ov
    );

    modport slave (
        input  ld, in, ld_lim, lim, cnten, wrap,
        output out, tc, ov
    );
endinterface

// File: rtl/upcnt_slice.sv
// One counter bit: register cell with load/clear, adder cell of the +1 chain, limit compare.
// Latency: q one edge after its controls; cout and eq are combinational.
// No flow control.
module upcnt_slice
    import upcounter_lim_pkg::*;
#(
    parameter bit IS_LSB = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic ld,
    input  logic ld_val,
    input  logic inc,
    input  logic zero,
    input  logic cin,
    input  logic lim_bit,
    output logic q,
    output logic cout,
    output logic eq
);

    logic bit_q;
    logic bit_d;
    logic sum;

    // Bit 0 adds the constant one (half adder); higher bits add the ripple carry
    if (IS_LSB) begin : g_ha
        logic unused_cin;
        assign unused_cin = cin;
        assign sum        = ~bit_q;
        assign cout       = bit_q;
    end else begin : g_fa
        assign sum  = bit_q ^ cin;
        assign cout = bit_q & cin;
    end

    always_comb begin
        bit_d = bit_q;
        if (ld) begin
            bit_d = ld_val;
        end else if (inc) begin
            bit_d = sum;
        end else if (zero) begin
            bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q  = bit_q;
    assign eq = ~(bit_q ^ lim_bit);

endmodule

// File: rtl/upcounter_lim.sv
// Loadable up-counter that counts toward a programmable limit, then wraps to 0 or saturates.
// Latency: out/ov/lim_q one edge after their inputs; tc combinational from out.
// No flow control: ld beats cnten, clr beats everything including ld_lim.
module upcounter_lim
    import upcounter_lim_pkg::*;
#(
    parameter int N = CNT_W
) (
    input  logic            clk,
    input  logic            clr,
    upcounter_lim_if.slave  bus
);

    logic [N-1:0] cnt;
    logic [N-1:0] eq;
    logic [N:0]   carry;
    logic [N-1:0] lim_q;
    logic [N-1:0] lim_d;
    logic         ov_q;
    logic         ov_d;
    logic         tc;
    logic         term;
    logic         inc;
    logic         zero;
    logic         unused_cout;

    assign carry[0]    = 1'b1;
    assign unused_cout = carry[N];

    assign tc   = &eq;
    // A count at the limit is a terminal event; it never increments, even when wrapping
    assign term = bus.cnten & tc & ~bus.ld;
    assign inc  = bus.cnten & ~tc & ~bus.ld;
    assign zero = term & (bus.wrap == WRAP);

    for (genvar i = 0; i < N; i++) begin : g_bit
        upcnt_slice #(
            .IS_LSB (i == 0)
        ) u_slice (
            .clk     (clk),
            .clr     (clr),
            .ld      (bus.ld),
            .ld_val  (bus.in[i]),
            .inc     (inc),
            .zero    (zero),
            .cin     (carry[i]),
            .lim_bit (lim_q[i]),
            .q       (cnt[i]),
            .cout    (carry[i+1]),
            .eq      (eq[i])
        );
    end

    always_comb begin
        lim_d = lim_q;
        if (bus.ld_lim) begin
            lim_d = bus.lim;
        end
        ov_d = term;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            lim_q <= {N{1'b1}};
            ov_q  <= 1'b0;
        end else begin
            lim_q <= lim_d;
            ov_q  <= ov_d;
        end
    end

    assign bus.out = cnt;
    assign bus.tc  = tc;
    assign bus.ov  = ov_q;

endmodule

// File: tb/tb_upcounter_lim.sv
// Directed scenarios followed by random traffic, all checked against a behavioural count/limit model.
module tb_upcounter_lim;
    import upcounter_lim_pkg::*;

    localparam int N = 5;
    localparam int M = 1 << N;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    upcounter_lim_if #(.N(N)) bus ();

    upcounter_lim #(.N(N)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: current count, limit, overflow pulse
    int m_cnt = 0;
    int m_lim = M - 1;
    int m_ov  = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input bit c, input bit ld, input int in_v,
                        input bit ldl, input int lim_v, input bit en, input bit wr);
        int nl;
        logic [N-1:0] in_b;
        logic [N-1:0] lim_b;
        in_b       = in_v[N-1:0];
        lim_b      = lim_v[N-1:0];
        clr        = c;
        bus.ld     = ld;
        bus.in     = in_b;
        bus.ld_lim = ldl;
        bus.lim    = lim_b;
        bus.cnten  = en;
        bus.wrap   = wr;
        @(posedge clk);
        #1;
        if (c) begin
            m_cnt = 0;
            m_lim = M - 1;
            m_ov  = 0;
        end else begin
            nl = ldl ? lim_v % M : m_lim;
            if (ld) begin
                m_cnt = in_v % M;
                m_ov  = 0;
            end else if (en && m_cnt == m_lim) begin
                m_ov = 1;
                if (wr) m_cnt = 0;
            end else if (en) begin
                m_cnt = (m_cnt + 1) % M;
                m_ov  = 0;
            end else begin
                m_ov = 0;
            end
            m_lim = nl;
        end
        check({tag, ".out"}, 8'(bus.out), 8'(m_cnt));
        check({tag, ".ov"},  8'(bus.ov),  8'(m_ov));
        check({tag, ".tc"},  8'(bus.tc),  8'(m_cnt == m_lim));
        check({tag, ".lim"}, 8'(dut.lim_q), 8'(m_lim));
    endtask

    initial begin
        clr        = 1'b0;
        bus.ld     = 1'b0;
        bus.in     = '0;
        bus.ld_lim = 1'b0;
        bus.lim    = '0;
        bus.cnten  = 1'b0;
        bus.wrap   = 1'b0;

        // Reset, then idle
        step("rst", 1, 0, 0, 0, 0, 0, 0);
        check("rst.out_const", 8'(bus.out), 8'd0);
        check("rst.lim_const", 8'(dut.lim_q), 8'd31);
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 0, 0);

        // Wrap at limit 5
        step("wrap5", 0, 0, 0, 1, 5, 1, WRAP);
        for (int i = 0; i < 5; i++) step("wrap5", 0, 0, 0, 0, 0, 1, WRAP);
        check("wrap5.end_out", 8'(bus.out), 8'd0);
        check("wrap5.end_ov", 8'(bus.ov), 8'd1);
        step("wrap5.after", 0, 0, 0, 0, 0, 1, WRAP);

        // Saturate at limit 3
        step("sat3", 0, 1, 0, 1, 3, 0, SAT);
        for (int i = 0; i < 7; i++) step("sat3", 0, 0, 0, 0, 0, 1, SAT);
        check("sat3.hold", 8'(bus.out), 8'd3);

        // Silent wrap through 31 -> 0 below the limit
        step("silent", 0, 1, 29, 1, 2, 0, WRAP);
        for (int i = 0; i < 6; i++) step("silent", 0, 0, 0, 0, 0, 1, WRAP);

        // Simultaneous events at out=4, lim_q=4
        step("sim.setup", 0, 1, 4, 1, 4, 0, WRAP);
        step("sim.ld", 0, 1, 10, 0, 0, 1, WRAP);
        check("sim.ld_out", 8'(bus.out), 8'd10);
        step("sim.setup2", 0, 1, 4, 0, 0, 0, WRAP);
        step("sim.ldlim", 0, 0, 0, 1, 9, 1, WRAP);
        check("sim.ldlim_ov", 8'(bus.ov), 8'd1);
        step("sim.next", 0, 0, 0, 0, 0, 1, WRAP);

        // Zero limit with wrap: stuck at 0, ov high every cycle
        step("lim0", 0, 1, 0, 1, 0, 0, WRAP);
        for (int i = 0; i < 3; i++) step("lim0", 0, 0, 0, 0, 0, 1, WRAP);

        // clr overrides ld, cnten and ld_lim mid-count
        step("clr.setup", 0, 1, 17, 1, 20, 0, WRAP);
        step("clr.hit", 1, 1, 7, 1, 3, 1, WRAP);
        for (int i = 0; i < 3; i++) step("clr.resume", 0, 0, 0, 0, 0, 1, WRAP);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, M - 1)),
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, M - 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
